// File: rtl/prod_accumulator_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | prod_accumulator_if : product-in / frame-sum-out valid/ready bus          |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface prod_accumulator_if #(
  parameter int ACC_W = 23
);
  logic             in_valid;
  logic             in_ready;
  logic [19:0]      in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/prod_accumulator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | prod_accumulator : sums N_TERMS 20-bit products per frame; PROD_ACC_SAT_EN |
// | selects clamp + sticky overflow instead of modulo wrap.  Rev 1.0           |
// +---------------------------------------------------------------------------+
module prod_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 23
) (
  input  wire logic         clk,
  input  wire logic         rst,
  prod_accumulator_if.slave bus
);
  localparam int              CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] out_sum, out_sum_nxt;
  logic             out_valid, out_valid_nxt;
  logic             accept;
  logic [ACC_W-1:0] term;

`ifdef PROD_ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  logic             ovf, ovf_nxt;
  logic             out_ovf, out_ovf_nxt;
  logic [ACC_W:0]   sum;
  logic             term_ovf;

  // Once clamped the frame stays clamped, even if later terms are zero.
  assign sum      = {1'b0, acc} + SUM_W'(bus.in_prod);
  assign term_ovf = ovf | sum[ACC_W];
  assign term     = term_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign bus.out_ovf = out_ovf;
`else
  assign term        = acc + ACC_W'(bus.in_prod);
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = (state == ACC) && !rst;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      out_sum   <= out_sum_nxt;
    end
  end

`ifdef PROD_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      ovf     <= ovf_nxt;
      out_ovf <= out_ovf_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    out_valid_nxt = out_valid;
    out_sum_nxt   = out_sum;
`ifdef PROD_ACC_SAT_EN
    ovf_nxt       = ovf;
    out_ovf_nxt   = out_ovf;
`endif
    case (state)
      ACC: begin
        if (accept) begin
          if (cnt == LAST_CNT) begin
            out_sum_nxt   = term;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
            acc_nxt       = '0;
            cnt_nxt       = '0;
`ifdef PROD_ACC_SAT_EN
            ovf_nxt       = 1'b0;
            out_ovf_nxt   = term_ovf;
`endif
          end else begin
            acc_nxt = term;
            cnt_nxt = cnt + CNT_W'(1);
`ifdef PROD_ACC_SAT_EN
            ovf_nxt = term_ovf;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid && bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_prod_accumulator.sv
`default_nettype none
// Bench: three accumulator builds (8x23, 1x23, 3x21) against a frame-sum model
// kept in unbounded integer arithmetic; wrap/clamp applied only at frame end.
module tb_prod_accumulator;
  localparam int ND = 3;
  localparam logic [19:0] FULL = 20'd1046529;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv   [ND];
  logic [19:0] ip   [ND];
  logic        ordy [ND];
  logic        ir   [ND];
  logic        ov   [ND];
  logic        oo   [ND];
  logic [22:0] os   [ND];

  int n_vec = 0;
  int n_err = 0;

  prod_accumulator_if #(.ACC_W(23)) bus0 ();
  prod_accumulator_if #(.ACC_W(23)) bus1 ();
  prod_accumulator_if #(.ACC_W(21)) bus2 ();

  prod_accumulator #(.N_TERMS(8), .ACC_W(23)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  prod_accumulator #(.N_TERMS(1), .ACC_W(23)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  prod_accumulator #(.N_TERMS(3), .ACC_W(21)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid = iv[0]; assign bus0.in_prod = ip[0]; assign bus0.out_ready = ordy[0];
  assign bus1.in_valid = iv[1]; assign bus1.in_prod = ip[1]; assign bus1.out_ready = ordy[1];
  assign bus2.in_valid = iv[2]; assign bus2.in_prod = ip[2]; assign bus2.out_ready = ordy[2];
  assign ir[0] = bus0.in_ready; assign ov[0] = bus0.out_valid; assign os[0] = bus0.out_sum;           assign oo[0] = bus0.out_ovf;
  assign ir[1] = bus1.in_ready; assign ov[1] = bus1.out_valid; assign os[1] = bus1.out_sum;           assign oo[1] = bus1.out_ovf;
  assign ir[2] = bus2.in_ready; assign ov[2] = bus2.out_valid; assign os[2] = {2'b00, bus2.out_sum};  assign oo[2] = bus2.out_ovf;

  // Reference model: pending-result flag, running frame sum and term count.
  bit      m_pend [ND];
  longint  m_sum  [ND];
  int      m_cnt  [ND];
  longint  m_last [ND];
  bit      m_ovf  [ND];

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 1 : 3;
  endfunction

  function automatic int w_of(input int d);
    return (d == 2) ? 21 : 23;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint maxv;
    for (int d = 0; d < ND; d++) begin
      maxv = (longint'(1) << w_of(d)) - 1;
      if (rst) begin
        m_pend[d] = 0; m_sum[d] = 0; m_cnt[d] = 0; m_last[d] = 0; m_ovf[d] = 0;
      end else if (m_pend[d]) begin
        if (ordy[d]) m_pend[d] = 0;
      end else if (iv[d]) begin
        m_sum[d] += longint'(ip[d]);
        m_cnt[d]++;
        if (m_cnt[d] == n_of(d)) begin
`ifdef PROD_ACC_SAT_EN
          m_ovf[d]  = (m_sum[d] > maxv);
          m_last[d] = m_ovf[d] ? maxv : m_sum[d];
`else
          m_ovf[d]  = 0;
          m_last[d] = m_sum[d] & maxv;
`endif
          m_pend[d] = 1; m_sum[d] = 0; m_cnt[d] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      check_value($sformatf("dut%0d_in_ready", d),  32'(ir[d]), 32'(!m_pend[d] && !rst));
      check_value($sformatf("dut%0d_out_valid", d), 32'(ov[d]), 32'(m_pend[d]));
      check_value($sformatf("dut%0d_out_sum", d),   32'(os[d]), 32'(m_last[d]));
      check_value($sformatf("dut%0d_out_ovf", d),   32'(oo[d]), 32'(m_ovf[d]));
    end
  endtask

  // Inputs change on the falling edge; the rising edge is modelled, then
  // outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int d, input logic [19:0] p);
    iv[d] = 1'b1; ip[d] = p;
    tick();
    iv[d] = 1'b0;
  endtask

  function automatic logic [19:0] pick_prod();
    case ($urandom_range(0, 3))
      0:       return 20'd0;
      1:       return FULL;
      default: return 20'($urandom_range(0, 1048575));
    endcase
  endfunction

  initial begin
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b1; ip[d] = 20'd1; ordy[d] = 1'b1;
      m_pend[d] = 0; m_sum[d] = 0; m_cnt[d] = 0; m_last[d] = 0; m_ovf[d] = 0;
    end

    // Reset held with in_valid asserted: nothing may be accepted.
    repeat (3) tick();
    check_value("rst_in_ready", 32'(ir[0]), 32'd0);
    check_value("rst_out_sum",  32'(os[0]), 32'd0);
    rst = 1'b0;
    iv[0] = 1'b0; iv[2] = 1'b0; ip[1] = 20'd5;
    tick();
    iv[1] = 1'b0;
    check_value("first_accept_valid", 32'(ov[1]), 32'd1);
    check_value("first_accept_sum",   32'(os[1]), 32'd5);
    tick();

    // Full-scale frame.
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; ip[0] = FULL;
      tick();
      if (i == 6) check_value("full_not_early", 32'(ov[0]), 32'd0);
    end
    iv[0] = 1'b0;
    check_value("full_valid", 32'(ov[0]), 32'd1);
    check_value("full_sum",   32'(os[0]), 32'd8372232);
    check_value("full_ovf",   32'(oo[0]), 32'd0);
    tick();

    // Backpressure with ignored in_valid pulses during HOLD.
    ordy[0] = 1'b0;
    for (int i = 1; i <= 8; i++) send(0, 20'(i));
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; ip[0] = 20'd99;
      tick();
      check_value("bp_sum",      32'(os[0]), 32'd36);
      check_value("bp_in_ready", 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(0, 20'd2);
    check_value("bp_next_sum", 32'(os[0]), 32'd16);
    tick();

    // Single-term frames: zero product, then random bubbles.
    send(1, 20'd0);
    check_value("n1_zero_valid", 32'(ov[1]), 32'd1);
    check_value("n1_zero_sum",   32'(os[1]), 32'd0);
    tick();
    for (int i = 0; i < 40; i++) begin
      iv[1] = 1'($urandom_range(0, 1)); ip[1] = pick_prod(); ordy[1] = 1'($urandom_range(0, 1));
      tick();
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    repeat (2) tick();

    // Overflow on the narrow build.
    for (int i = 0; i < 3; i++) send(2, FULL);
`ifdef PROD_ACC_SAT_EN
    check_value("ovf_sum",  32'(os[2]), 32'd2097151);
    check_value("ovf_flag", 32'(oo[2]), 32'd1);
`else
    check_value("ovf_sum",  32'(os[2]), 32'd1042435);
    check_value("ovf_flag", 32'(oo[2]), 32'd0);
`endif
    tick();
    for (int i = 0; i < 3; i++) send(2, 20'd1);
    check_value("ovf_next_sum",  32'(os[2]), 32'd3);
    check_value("ovf_next_flag", 32'(oo[2]), 32'd0);
    tick();

    // Mid-frame reset discards the partial sum.
    for (int i = 0; i < 5; i++) send(0, 20'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 20'd10);
    check_value("midrst_sum",   32'(os[0]), 32'd80);
    check_value("midrst_valid", 32'(ov[0]), 32'd1);
    tick();

    // Random traffic on the multi-term builds, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < ND; d += 2) begin
        iv[d]   = ($urandom_range(0, 9) < 7);
        ip[d]   = pick_prod();
        ordy[d] = ($urandom_range(0, 9) < 6);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin iv[d] = 1'b0; ordy[d] = 1'b1; end
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/prod_accumulator.md
# prod_accumulator

Sequential accumulate stage directly downstream of the 10x10 unsigned `multiplier`: it takes the 20-bit `out` product through a valid/ready handshake and sums a fixed-length frame of `N_TERMS` products. It presents the frame sum on a registered valid/ready output port. Typical use is as the MAC back end of a dot-product or FIR datapath, with the multiplier feeding `in_prod` combinationally.

## Interface
- `N_TERMS`, default 8: products per frame; legal range ≥ 1.
- `ACC_W`, default 23: accumulator and output width; legal range ≥ 20. The default is exact for 8 × (1023·1023).
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_prod` is valid.
- `in_ready`  out  1  stage can accept a product.
- `in_prod`  in  20  unsigned product from `multiplier.out`.
- `out_valid`  out  1  `out_sum` holds a completed frame sum.
- `out_ready`  in  1  consumer accepts `out_sum`.
- `out_sum`  out  ACC_W  unsigned frame sum, registered.
- `out_ovf`  out  1  frame overflowed `ACC_W`; see Configuration.

## Operation
- **States:**
  - ACC (accumulating).
  - HOLD (result pending).
- **Reset values:** state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0.
- **in_ready:** `in_ready = (state==ACC) && !rst`. It is combinational from state only and never depends on `in_valid`.
- **ACC, accept (in_valid && in_ready):**
  - acc ← acc + zero-extended `in_prod`; cnt ← cnt+1.
  - When cnt==N_TERMS-1 on accept: out_sum ← acc + in_prod (final term included), out_valid ← 1, state ← HOLD, acc ← 0, cnt ← 0.
- **ACC, no accept:** all registers hold.
- **HOLD:**
  - in_ready=0, and `in_valid` is ignored.
  - out_sum, out_ovf and out_valid stay stable until `out_valid && out_ready`.
  - On that handshake: out_valid ← 0, state ← ACC. A new product can be accepted the following cycle.
- **Arithmetic:** unsigned only. The adder is ACC_W+1 bits wide; its carry-out is the overflow event for the current term.
- **N_TERMS=1:** every accepted product goes straight to HOLD with out_sum=in_prod.
- **Reset mid-frame or in HOLD:** the partial sum and the pending result are discarded. No output handshake occurs.
- **out_ready while out_valid=0:** no effect.

## Timing
- out_valid rises on the clock edge that accepts the N_TERMS-th product, i.e. 1-cycle latency from the last accept.
- Peak throughput: N_TERMS products per N_TERMS+1 cycles. The extra cycle is the HOLD cycle, assuming `out_ready` is held high.
- Backpressure: HOLD persists for any number of cycles while out_ready=0.
- First accept is possible on the first edge after `rst` deasserts.
- No combinational path from `in_valid`/`in_prod` to any output.

## Configuration
- Macro: `PROD_ACC_SAT_EN`.
- **Defined:**
  - On carry-out the accumulator clamps to 2^ACC_W−1 and stays clamped for the rest of the frame.
  - A per-frame sticky overflow bit is set and copied to `out_ovf` with out_sum.
  - The overflow bit clears on frame start and on reset.
- **Undefined:**
  - The accumulator wraps modulo 2^ACC_W.
  - `out_ovf` is tied 0.
  - No saturation logic is synthesised.

## Test plan
- **Reset:** hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_sum=0, out_ovf=0. Release rst with a 1-product frame pending → no spurious accept during reset.
- **Full-scale frame (N_TERMS=8, ACC_W=23):** 8 back-to-back products of 1046529 (1023·1023) with out_ready=1 → out_valid exactly 1 cycle after the 8th accept, out_sum=8372232, out_ovf=0.
- **Backpressure:** products 1..8 with out_ready=0 for 5 cycles → out_sum=36 stays stable, in_ready=0 throughout HOLD, extra in_valid pulses are not counted. The next frame of eight 2s yields out_sum=16.
- **Bubbles and edge case (N_TERMS=1):** random in_valid gaps with 0 and 1046529 → each accept yields one result equal to the product. A zero product gives out_sum=0, out_valid=1.
- **Overflow (ACC_W=21):** 3 × 1046529.
  - With `PROD_ACC_SAT_EN`: out_sum=2097151, out_ovf=1. The next frame of 3 × 1 gives out_sum=3, out_ovf=0.
  - Without it: out_sum=1042435, out_ovf=0.
- **Mid-frame reset:** accept 5 of 8 products of value 100, pulse rst 1 cycle, then send 8 × 10 → out_sum=80 with no stale partial sum.
